cache_write_interface: RTL and testbench

Write-side counterpart of the cache read streamer: it accepts write transactions (cache address, length, id), takes a stream of IWIDTH-wide data beats, splits each beat into CWIDTH-wide words and writes them to the cache SRAM port one word per accepted cycle. It sits between the memory controller's fill/refill datapath and the cache data array. It reports each completed transaction so the controller can mark the line valid.

---
 rtl/cache_write_if.sv | 37 +++
 rtl/cache_write_interface.sv | 104 ++++++++++
 tb/tb_cache_write_interface.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_write_if.sv
// cache_write_if: write-path bus of cache_write_interface (transaction, beat stream, cache SRAM port)
// Ports: OUT_ready/IN_valid/IN_id/IN_len/IN_addr transaction handshake; OUT_dataReady/IN_dataValid/IN_data beat stream;
// IN_CACHE_ready/OUT_CACHE_ce/OUT_CACHE_we/OUT_CACHE_addr/OUT_CACHE_data cache port; OUT_cacheWriteValid/OUT_cacheWriteId completion.
// slave is the write engine side, master the producer/cache side.
interface cache_write_if #(
   parameter int ADDR_BITS = 10,
   parameter int LEN_BITS = 8,
   parameter int IWIDTH = 128,
   parameter int CWIDTH = 32,
   parameter int ID_LEN = 2
);
   logic OUT_ready;
   logic IN_valid;
   logic [ID_LEN-1:0] IN_id;
   logic [LEN_BITS-1:0] IN_len;
   logic [ADDR_BITS-1:0] IN_addr;
   logic OUT_dataReady;
   logic IN_dataValid;
   logic [IWIDTH-1:0] IN_data;
   logic IN_CACHE_ready;
   logic OUT_CACHE_ce;
   logic OUT_CACHE_we;
   logic [ADDR_BITS-1:0] OUT_CACHE_addr;
   logic [CWIDTH-1:0] OUT_CACHE_data;
   logic OUT_cacheWriteValid;
   logic [ID_LEN-1:0] OUT_cacheWriteId;
   modport slave (
      input IN_valid, IN_id, IN_len, IN_addr, IN_dataValid, IN_data, IN_CACHE_ready,
      output OUT_ready, OUT_dataReady, OUT_CACHE_ce, OUT_CACHE_we, OUT_CACHE_addr, OUT_CACHE_data,
      output OUT_cacheWriteValid, OUT_cacheWriteId
   );
   modport master (
      output IN_valid, IN_id, IN_len, IN_addr, IN_dataValid, IN_data, IN_CACHE_ready,
      input OUT_ready, OUT_dataReady, OUT_CACHE_ce, OUT_CACHE_we, OUT_CACHE_addr, OUT_CACHE_data,
      input OUT_cacheWriteValid, OUT_cacheWriteId
   );
endinterface

// File: rtl/cache_write_interface.sv
// cache_write_interface: splits buffered IWIDTH beats into CWIDTH cache writes for queued fill transactions
// Ports: clk; rst (async, active-low); bus (cache_write_if.slave) carrying the transaction handshake,
// the beat stream, the active-low cache SRAM write port and the transaction-complete pulse.
module cache_write_interface #(
   parameter int ADDR_BITS = 10,
   parameter int LEN_BITS = 8,
   parameter int IWIDTH = 128,
   parameter int CWIDTH = 32,
   parameter int BUF_LEN = 4,
   parameter int ID_LEN = 2,
   parameter int CLSIZE_E = 7
) (
   input logic clk,
   input logic rst,
   cache_write_if.slave bus
);
   localparam int WNUM = IWIDTH / CWIDTH;
   localparam int WB = WNUM > 1 ? $clog2(WNUM) : 1;
   localparam int OFFS_BITS = CLSIZE_E - $clog2(CWIDTH / 8);
   localparam int PB = BUF_LEN > 1 ? $clog2(BUF_LEN) : 1;
   localparam int CB = $clog2(BUF_LEN + 1);
   typedef struct packed {
      logic v;
      logic [ID_LEN-1:0] id;
      logic [LEN_BITS-1:0] len;
      logic [ADDR_BITS-1:0] addr;
   } txn_t;
   txn_t cur_q, cur_d, nxt_q, nxt_d, in_t;
   logic [LEN_BITS-1:0] prog_q, prog_d;
   logic [WB-1:0] widx_q, widx_d;
   logic [IWIDTH-1:0] mem_q [BUF_LEN];
   logic [IWIDTH-1:0] mem_d [BUF_LEN];
   logic [PB-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CB-1:0] cnt_q, cnt_d;
   logic done_q, done_d;
   logic [ID_LEN-1:0] done_id_q, done_id_d;
   logic [IWIDTH-1:0] head;
   logic issue, acc, is_last, last, pop, push, ready, take;
   assign head = mem_q[rd_q];
   assign issue = cur_q.v && cnt_q != '0;
   assign acc = issue && bus.IN_CACHE_ready;
   assign is_last = prog_q == cur_q.len;
   assign last = acc && is_last;
   // The final word of a transaction also frees its beat, discarding any unused lanes.
   assign pop = acc && (widx_q == WB'(WNUM - 1) || is_last);
   assign push = bus.IN_dataValid && bus.OUT_dataReady;
   assign ready = !nxt_q.v || last;
   assign take = bus.IN_valid && ready;
   assign in_t = '{v: 1'b1, id: bus.IN_id, len: bus.IN_len, addr: bus.IN_addr};
   assign bus.OUT_ready = ready;
   assign bus.OUT_dataReady = cnt_q < CB'(BUF_LEN);
   assign bus.OUT_CACHE_ce = !issue;
   assign bus.OUT_CACHE_we = !issue;
   // Offset wraps inside the cache line; the line index stays fixed for the whole transaction.
   assign bus.OUT_CACHE_addr = {cur_q.addr[ADDR_BITS-1:OFFS_BITS], cur_q.addr[OFFS_BITS-1:0] + prog_q[OFFS_BITS-1:0]};
   assign bus.OUT_CACHE_data = head[widx_q*CWIDTH +: CWIDTH];
   assign bus.OUT_cacheWriteValid = done_q;
   assign bus.OUT_cacheWriteId = done_id_q;
   always_comb begin
      cur_d = cur_q;
      nxt_d = nxt_q;
      mem_d = mem_q;
      if (last) begin
         cur_d = nxt_q.v ? nxt_q : (take ? in_t : '0);
         nxt_d = nxt_q.v && take ? in_t : '0;
      end else if (take) begin
         if (cur_q.v) nxt_d = in_t;
         else cur_d = in_t;
      end
      if (push) mem_d[wr_q] = bus.IN_data;
      prog_d = last ? '0 : acc ? prog_q + 1'b1 : prog_q;
      widx_d = last ? '0 : acc ? widx_q + 1'b1 : widx_q;
      rd_d = !pop ? rd_q : rd_q == PB'(BUF_LEN - 1) ? '0 : rd_q + 1'b1;
      wr_d = !push ? wr_q : wr_q == PB'(BUF_LEN - 1) ? '0 : wr_q + 1'b1;
      cnt_d = cnt_q + CB'(push) - CB'(pop);
      done_d = last;
      done_id_d = last ? cur_q.id : done_id_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_q <= '0;
         nxt_q <= '0;
         prog_q <= '0;
         widx_q <= '0;
         mem_q <= '{default: '0};
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
         done_q <= 1'b0;
         done_id_q <= '0;
      end else begin
         cur_q <= cur_d;
         nxt_q <= nxt_d;
         prog_q <= prog_d;
         widx_q <= widx_d;
         mem_q <= mem_d;
         rd_q <= rd_d;
         wr_q <= wr_d;
         cnt_q <= cnt_d;
         done_q <= done_d;
         done_id_q <= done_id_d;
      end
   end
endmodule

// File: tb/tb_cache_write_interface.sv
// tb_cache_write_interface: directed and randomized bench for cache_write_interface against a transaction-level write model
module tb_cache_write_interface;
   localparam int AB = 10, LB = 8, IW = 128, CW = 32, IL = 2, LINE_W = 32;
   typedef struct packed {
      logic [IL-1:0] id;
      logic [LB-1:0] len;
      logic [AB-1:0] addr;
      logic [16*CW-1:0] w;
   } txn_t;
   typedef struct packed {
      logic [AB-1:0] addr;
      logic [CW-1:0] data;
      logic last;
      logic [IL-1:0] id;
   } wr_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   cache_write_if #(.ADDR_BITS(AB), .LEN_BITS(LB), .IWIDTH(IW), .CWIDTH(CW), .ID_LEN(IL)) bus ();
   cache_write_interface #(.ADDR_BITS(AB), .LEN_BITS(LB), .IWIDTH(IW), .CWIDTH(CW), .BUF_LEN(4), .ID_LEN(IL), .CLSIZE_E(7)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   int checks = 0, failures = 0, nwr = 0;
   txn_t txq[$];
   txn_t hold[$];
   logic [IW-1:0] bq[$];
   wr_t expq[$];
   logic crdy = 1'b1, dv_en = 1'b1, pend = 1'b0;
   logic [IL-1:0] pend_id = '0;
   logic s_ce, s_we, s_ready, s_dready, s_valid, s_txacc, s_bacc, s_wr, s_wlast;
   logic [AB-1:0] s_addr, h_addr;
   logic [CW-1:0] s_data, h_data;
   logic [IL-1:0] s_id;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [16*CW-1:0] rand_words();
      logic [16*CW-1:0] w;
      for (int i = 0; i < 16; i++) w[i*CW +: CW] = $urandom;
      return w;
   endfunction
   task automatic enq(input logic [IL-1:0] id, input logic [LB-1:0] len, input logic [AB-1:0] addr, input logic [16*CW-1:0] w);
      txn_t t;
      logic [IW-1:0] b;
      t.id = id;
      t.len = len;
      t.addr = addr;
      t.w = w;
      txq.push_back(t);
      for (int i = 0; i <= int'(len); i += 4) begin
         for (int k = 0; k < 4; k++) b[k*CW +: CW] = (i + k <= int'(len)) ? w[(i+k)*CW +: CW] : $urandom;
         bq.push_back(b);
      end
   endtask
   task automatic step();
      txn_t t;
      wr_t e;
      bus.IN_valid = txq.size() != 0;
      if (txq.size() != 0) begin
         bus.IN_id = txq[0].id;
         bus.IN_len = txq[0].len;
         bus.IN_addr = txq[0].addr;
      end
      bus.IN_dataValid = dv_en && bq.size() != 0;
      bus.IN_data = bq.size() != 0 ? bq[0] : '0;
      bus.IN_CACHE_ready = crdy;
      @(negedge clk);
      s_ce = bus.OUT_CACHE_ce;
      s_we = bus.OUT_CACHE_we;
      s_ready = bus.OUT_ready;
      s_dready = bus.OUT_dataReady;
      s_valid = bus.OUT_cacheWriteValid;
      s_id = bus.OUT_cacheWriteId;
      s_addr = bus.OUT_CACHE_addr;
      s_data = bus.OUT_CACHE_data;
      if (pend) begin
         chk("done_valid", s_valid, 1);
         chk("done_id", s_id, pend_id);
      end else chk("done_idle", s_valid, 0);
      pend = 1'b0;
      s_wlast = 1'b0;
      s_wr = !s_ce && crdy;
      if (!s_ce) chk("we_with_ce", s_we, 0);
      if (s_wr) begin
         chk("write_expected", expq.size() != 0, 1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("wr_addr", s_addr, e.addr);
            chk("wr_data", s_data, e.data);
            nwr++;
            if (e.last) begin
               pend = 1'b1;
               pend_id = e.id;
               s_wlast = 1'b1;
            end
         end
      end
      s_txacc = bus.IN_valid && s_ready;
      s_bacc = bus.IN_dataValid && s_dready;
      if (s_txacc) begin
         t = txq.pop_front();
         for (int i = 0; i <= int'(t.len); i++) begin
            e.addr = (t.addr & ~AB'(LINE_W - 1)) | ((t.addr + AB'(i)) & AB'(LINE_W - 1));
            e.data = t.w[i*CW +: CW];
            e.last = i == int'(t.len);
            e.id = t.id;
            expq.push_back(e);
         end
      end
      if (s_bacc) void'(bq.pop_front());
      @(posedge clk);
      #1;
   endtask
   task automatic drain(input bit rnd);
      int n = 0;
      while ((txq.size() != 0 || bq.size() != 0 || expq.size() != 0 || pend) && n < 3000) begin
         if (rnd) begin
            crdy = $urandom_range(0, 3) != 0;
            dv_en = $urandom_range(0, 3) != 0;
         end
         step();
         n++;
      end
      chk("drain_in_time", n < 3000, 1);
      crdy = 1'b1;
      dv_en = 1'b1;
   endtask
   initial begin
      int base, gaps;
      logic [16*CW-1:0] w;
      bus.IN_valid = 1'b0;
      bus.IN_id = '0;
      bus.IN_len = '0;
      bus.IN_addr = '0;
      bus.IN_dataValid = 1'b0;
      bus.IN_data = '0;
      bus.IN_CACHE_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step();
      chk("rst_ready", s_ready, 1);
      chk("rst_dready", s_dready, 1);
      chk("rst_ce", s_ce, 1);
      chk("rst_we", s_we, 1);
      rst = 1'b1;
      step();
      chk("idle_ce", s_ce, 1);
      w = rand_words();
      enq(2'd1, 8'd3, 10'h010, w);
      step();
      chk("lat_accept", {s_txacc, s_bacc}, 2'b11);
      step();
      chk("lat_first_write", {s_wr, s_addr, s_data}, {1'b1, 10'h010, w[31:0]});
      repeat (3) begin
         step();
         chk("tA_continuous", s_wr, 1);
      end
      step();
      chk("tA_done", {s_valid, s_id}, {1'b1, 2'd1});
      enq(2'd2, 8'd3, 10'h03E, rand_words());
      drain(0);
      base = nwr;
      enq(2'd3, 8'd5, 10'h1A3, rand_words());
      drain(0);
      chk("partial_writes", nwr - base, 6);
      chk("partial_fifo_free", s_dready, 1);
      enq(2'd0, 8'd0, 10'h2C7, rand_words());
      drain(0);
      enq(2'd2, 8'd7, 10'h35C, rand_words());
      step();
      step();
      step();
      crdy = 1'b0;
      step();
      chk("stall_ce", s_ce, 0);
      h_addr = s_addr;
      h_data = s_data;
      repeat (2) begin
         step();
         chk("stall_hold", {s_ce, s_addr, s_data}, {1'b0, h_addr, h_data});
      end
      crdy = 1'b1;
      step();
      chk("stall_resume", {s_wr, s_addr, s_data}, {1'b1, h_addr, h_data});
      drain(0);
      enq(2'd1, 8'd3, 10'h0F0, rand_words());
      enq(2'd2, 8'd3, 10'h11D, rand_words());
      enq(2'd3, 8'd3, 10'h3FF, rand_words());
      hold = txq;
      txq.delete();
      repeat (3) step();
      txq = hold;
      step();
      chk("b2b_acc1", s_txacc, 1);
      step();
      chk("b2b_acc2", s_txacc, 1);
      step();
      chk("b2b_full", s_ready, 0);
      step();
      chk("b2b_full2", s_ready, 0);
      step();
      chk("b2b_acc3_on_last", {s_txacc, s_wlast}, 2'b11);
      gaps = 0;
      repeat (8) begin
         step();
         if (!s_wr) gaps++;
      end
      chk("b2b_no_bubble", gaps, 0);
      drain(0);
      enq(2'd3, 8'd7, 10'h088, rand_words());
      step();
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_mid_ce", bus.OUT_CACHE_ce, 1);
      chk("rst_mid_we", bus.OUT_CACHE_we, 1);
      txq.delete();
      bq.delete();
      expq.delete();
      pend = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("rst_rel_ready", s_ready, 1);
      chk("rst_rel_dready", s_dready, 1);
      base = nwr;
      enq(2'd1, 8'd0, 10'h155, rand_words());
      drain(0);
      chk("rst_rel_one_write", nwr - base, 1);
      for (int i = 0; i < 40; i++) begin
         enq(IL'($urandom), LB'($urandom_range(0, 15)), AB'($urandom), rand_words());
         if ($urandom_range(0, 2) == 0) drain(1);
      end
      drain(1);
      step();
      chk("final_idle_ce", s_ce, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
